// File: rtl/spike_collector_pkg.sv
// rtl/spike_collector_pkg.sv - shared constants, state encoding and class mapping for the spike collector
package rancpkg_out;

  localparam int NUM_OUTPUT    = 250;
  localparam int NUM_CLASSES   = 10;
  localparam int CNT_W         = 5;
  localparam int IDX_W         = 8;
  localparam int CLS_W         = 4;
  localparam int PIC_W         = 16;
  localparam int NUM_PICTURE   = 3;
  localparam int LAYER_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_ARGMAX,
    ST_DONE
  } state_t;

  typedef logic [NUM_CLASSES-1:0][CNT_W-1:0] cnt_arr_t;

  function automatic logic [CLS_W-1:0] class_of(input logic [IDX_W-1:0] idx);
    return CLS_W'(idx % IDX_W'(NUM_CLASSES));
  endfunction

endpackage

// File: rtl/spike_collector_if.sv
// rtl/spike_collector_if.sv - packet input and result output bundle of the spike collector
interface spike_collector_if;
  import rancpkg_out::*;

  logic                  start;
  logic                  tick;
  logic [IDX_W-1:0]      packet_out;
  logic                  packet_out_valid;
  logic                  result_valid;
  logic [NUM_OUTPUT-1:0] result_spikes;
  logic [CLS_W-1:0]      result_class;
  logic [CNT_W-1:0]      result_count;
  logic [PIC_W-1:0]      picture_idx;
  logic                  done;
  logic                  range_error;
  logic                  overrun_error;

  modport master (
    output start, tick, packet_out, packet_out_valid,
    input  result_valid, result_spikes, result_class, result_count,
    input  picture_idx, done, range_error, overrun_error
  );

  modport slave (
    input  start, tick, packet_out, packet_out_valid,
    output result_valid, result_spikes, result_class, result_count,
    output picture_idx, done, range_error, overrun_error
  );

endinterface

// File: rtl/spike_collector_argmax.sv
// rtl/spike_collector_argmax.sv - sequential argmax over the latched per-class spike counts
module spike_argmax
  import rancpkg_out::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  cnt_arr_t         i_counts,
  output logic             o_done,
  output logic [CLS_W-1:0] o_class,
  output logic [CNT_W-1:0] o_count
);

  logic             r_busy;
  logic             r_done;
  logic [CLS_W-1:0] r_idx;
  logic [CLS_W-1:0] r_cls;
  logic [CNT_W-1:0] r_cnt;

  // Class 0 seeds the best on the start cycle; strict > keeps ties at the lowest class.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_idx  <= '0;
      r_cls  <= '0;
      r_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_busy <= 1'b1;
        r_idx  <= CLS_W'(1);
        r_cls  <= '0;
        r_cnt  <= i_counts[0];
      end else if (r_busy) begin
        if (i_counts[r_idx] > r_cnt) begin
          r_cls <= r_idx;
          r_cnt <= i_counts[r_idx];
        end
        if (r_idx == CLS_W'(NUM_CLASSES-1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_idx <= r_idx + CLS_W'(1);
        end
      end
    end
  end

  assign o_done  = r_done;
  assign o_class = r_cls;
  assign o_count = r_cnt;

endmodule

// File: rtl/spike_collector.sv
// rtl/spike_collector.sv - per-window spike capture, latency skip and per-picture class vote
module spike_collector
  import rancpkg_out::*;
(
  input  logic              clk,
  input  logic              reset_n,
  spike_collector_if.slave  bus
);

  state_t                r_state, w_state_nxt;
  logic [NUM_OUTPUT-1:0] r_vec, w_vec_nxt, r_snap_vec, r_res_spikes;
  cnt_arr_t              r_cnt, w_cnt_nxt, r_snap_cnt;
  logic [PIC_W-1:0]      r_win, r_snap_pic, r_pic;
  logic                  r_am_start, r_res_valid, r_range_err, r_overrun_err;
  logic [CLS_W-1:0]      r_res_class;
  logic [CNT_W-1:0]      r_res_count;

  logic                  w_collecting, w_tick_close, w_in_range, w_pkt_ok, w_pkt_bad;
  logic                  w_keep, w_arm, w_last_pic;
  logic [IDX_W-1:0]      w_bitpos;
  logic [CLS_W-1:0]      w_cls;
  logic [PIC_W-1:0]      w_win_inc;
  logic                  w_am_done;
  logic [CLS_W-1:0]      w_am_class;
  logic [CNT_W-1:0]      w_am_count;

  assign w_collecting = (r_state == ST_COLLECT) || (r_state == ST_ARGMAX);
  assign w_tick_close = w_collecting && bus.tick;
  assign w_in_range   = bus.packet_out < IDX_W'(NUM_OUTPUT);
  assign w_pkt_ok     = w_collecting && bus.packet_out_valid && w_in_range;
  assign w_pkt_bad    = w_collecting && bus.packet_out_valid && !w_in_range;
  assign w_bitpos     = IDX_W'(NUM_OUTPUT-1) - bus.packet_out;
  assign w_cls        = class_of(bus.packet_out);
  assign w_win_inc    = r_win + PIC_W'(1);
  assign w_keep       = (r_state == ST_COLLECT) && bus.tick && (w_win_inc > PIC_W'(LAYER_LATENCY));
  assign w_arm        = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last_pic   = r_snap_pic >= PIC_W'(NUM_PICTURE-1);

  // A packet landing with the closing tick belongs to the freshly cleared window.
  always_comb begin
    w_vec_nxt = w_tick_close ? '0 : r_vec;
    w_cnt_nxt = w_tick_close ? '0 : r_cnt;
    if (w_pkt_ok) begin
      if (!w_vec_nxt[w_bitpos]) begin
        w_cnt_nxt[w_cls] = w_cnt_nxt[w_cls] + CNT_W'(1);
      end
      w_vec_nxt[w_bitpos] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_arm) w_state_nxt = ST_COLLECT;
      ST_COLLECT: if (w_keep) w_state_nxt = ST_ARGMAX;
      ST_ARGMAX:  if (w_am_done) w_state_nxt = w_last_pic ? ST_DONE : ST_COLLECT;
      ST_DONE:    if (w_arm) w_state_nxt = ST_COLLECT;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vec         <= '0;
      r_cnt         <= '0;
      r_snap_vec    <= '0;
      r_snap_cnt    <= '0;
      r_snap_pic    <= '0;
      r_win         <= '0;
      r_pic         <= '0;
      r_am_start    <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_spikes  <= '0;
      r_res_class   <= '0;
      r_res_count   <= '0;
      r_range_err   <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_am_start  <= w_keep;
      r_res_valid <= 1'b0;
      if (w_arm) begin
        r_vec         <= '0;
        r_cnt         <= '0;
        r_win         <= '0;
        r_pic         <= '0;
        r_range_err   <= 1'b0;
        r_overrun_err <= 1'b0;
      end else begin
        if (w_collecting) begin
          r_vec <= w_vec_nxt;
          r_cnt <= w_cnt_nxt;
        end
        if (w_tick_close) r_win <= w_win_inc;
        if (w_keep) begin
          r_snap_vec <= r_vec;
          r_snap_cnt <= r_cnt;
          r_snap_pic <= w_win_inc - PIC_W'(LAYER_LATENCY + 1);
        end
        if (w_pkt_bad) r_range_err <= 1'b1;
        // A window closing during the vote is lost, but its number is still consumed.
        if (w_tick_close && (r_state == ST_ARGMAX)) r_overrun_err <= 1'b1;
        if ((r_state == ST_ARGMAX) && w_am_done) begin
          r_res_valid  <= 1'b1;
          r_res_spikes <= r_snap_vec;
          r_res_class  <= w_am_class;
          r_res_count  <= w_am_count;
          r_pic        <= r_snap_pic;
        end
      end
    end
  end

  spike_argmax u_argmax (
    .clk     (clk),
    .reset_n (reset_n),
    .i_start (r_am_start),
    .i_counts(r_snap_cnt),
    .o_done  (w_am_done),
    .o_class (w_am_class),
    .o_count (w_am_count)
  );

  assign bus.result_valid  = r_res_valid;
  assign bus.result_spikes = r_res_spikes;
  assign bus.result_class  = r_res_class;
  assign bus.result_count  = r_res_count;
  assign bus.picture_idx   = r_pic;
  assign bus.done          = (r_state == ST_DONE);
  assign bus.range_error   = r_range_err;
  assign bus.overrun_error = r_overrun_err;

endmodule

// File: tb/tb_spike_collector.sv
// tb/tb_spike_collector.sv - window table plus scoreboard bench for spike_collector
module tb_spike_collector;
  import rancpkg_out::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  spike_collector_if bus();

  spike_collector dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  typedef struct {
    int npk;
    int pk[6];
    bit with_tick;
    bit exp_res;
    bit drain;
    int cls;
    int cnt;
  } win_t;

  typedef struct {
    int                    cyc;
    int                    pic;
    int                    cls;
    int                    cnt;
    logic [NUM_OUTPUT-1:0] spk;
  } exp_t;

  win_t                  tbl[12];
  exp_t                  q[$];
  exp_t                  e_mon;
  exp_t                  e_new;
  logic [NUM_OUTPUT-1:0] cur_vec;
  int n_tests   = 0;
  int n_fail    = 0;
  int n_results = 0;
  int cyc       = 0;
  int w_model   = 0;
  int saved;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.result_valid === 1'b1) begin
      n_results++;
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got result_valid=1 picture_idx=%0d expected no result", bus.picture_idx);
      end else begin
        e_mon = q.pop_front();
        chk("latency_cycle", 256'(cyc), 256'(e_mon.cyc));
        chk("picture_idx", 256'(bus.picture_idx), 256'(e_mon.pic));
        chk("result_class", 256'(bus.result_class), 256'(e_mon.cls));
        chk("result_count", 256'(bus.result_count), 256'(e_mon.cnt));
        chk("result_spikes", 256'(bus.result_spikes), 256'(e_mon.spk));
      end
    end
  end

  task automatic step(input bit v, input int idx, input bit t, input bit s);
    bus.packet_out_valid = v;
    bus.packet_out       = 8'(idx);
    bus.tick             = t;
    bus.start            = s;
    @(negedge clk);
    bus.packet_out_valid = 1'b0;
    bus.packet_out       = '0;
    bus.tick             = 1'b0;
    bus.start            = 1'b0;
  endtask

  task automatic model_pkt(input int idx);
    if (idx < NUM_OUTPUT) cur_vec[NUM_OUTPUT-1-idx] = 1'b1;
  endtask

  // Called just before the tick is driven; the result is due 11 edges after the tick edge.
  task automatic model_tick(input bit push, input int cls, input int cnt);
    w_model++;
    if (push) begin
      e_new.cyc = cyc + 12;
      e_new.pic = w_model - LAYER_LATENCY - 1;
      e_new.cls = cls;
      e_new.cnt = cnt;
      e_new.spk = cur_vec;
      q.push_back(e_new);
    end
    cur_vec = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL result_timeout: got %0d pending expected 0 pending", q.size());
      q.delete();
    end
  endtask

  task automatic arm();
    w_model = 0;
    cur_vec = '0;
    step(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic run_window(input int k);
    for (int i = 0; i < tbl[k].npk; i++) begin
      if (tbl[k].with_tick && i == tbl[k].npk - 1) begin
        model_tick(tbl[k].exp_res, tbl[k].cls, tbl[k].cnt);
        model_pkt(tbl[k].pk[i]);
        step(1'b1, tbl[k].pk[i], 1'b1, 1'b0);
      end else begin
        model_pkt(tbl[k].pk[i]);
        step(1'b1, tbl[k].pk[i], 1'b0, 1'b0);
      end
    end
    if (!tbl[k].with_tick) begin
      model_tick(tbl[k].exp_res, tbl[k].cls, tbl[k].cnt);
      step(1'b0, 0, 1'b1, 1'b0);
    end
    if (tbl[k].drain) drain();
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 0, 1'b1, 1'b0);
      repeat (13) @(negedge clk);
    end
  endtask

  initial begin
    tbl[0]  = '{1, '{3, 0, 0, 0, 0, 0}, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[1]  = '{1, '{3, 0, 0, 0, 0, 0}, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[2]  = '{4, '{3, 13, 23, 5, 0, 0}, 1'b0, 1'b1, 1'b1, 3, 3};
    tbl[3]  = '{6, '{7, 7, 17, 4, 14, 9}, 1'b1, 1'b1, 1'b1, 4, 2};
    tbl[4]  = '{1, '{0, 0, 0, 0, 0, 0}, 1'b0, 1'b1, 1'b1, 0, 1};
    tbl[5]  = '{0, '{0, 0, 0, 0, 0, 0}, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[6]  = '{0, '{0, 0, 0, 0, 0, 0}, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[7]  = '{2, '{2, 250, 0, 0, 0, 0}, 1'b0, 1'b1, 1'b0, 2, 1};
    tbl[8]  = '{1, '{8, 0, 0, 0, 0, 0}, 1'b0, 1'b1, 1'b1, 8, 1};
    tbl[9]  = '{0, '{0, 0, 0, 0, 0, 0}, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[10] = '{0, '{0, 0, 0, 0, 0, 0}, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[11] = '{0, '{0, 0, 0, 0, 0, 0}, 1'b0, 1'b1, 1'b1, 0, 0};

    reset_n              = 1'b0;
    bus.start            = 1'b0;
    bus.tick             = 1'b0;
    bus.packet_out       = '0;
    bus.packet_out_valid = 1'b0;
    cur_vec              = '0;
    repeat (3) @(negedge clk);
    chk("reset_result_valid", 256'(bus.result_valid), 256'(0));
    chk("reset_done", 256'(bus.done), 256'(0));
    chk("reset_range_error", 256'(bus.range_error), 256'(0));
    chk("reset_overrun_error", 256'(bus.overrun_error), 256'(0));
    chk("reset_picture_idx", 256'(bus.picture_idx), 256'(0));
    chk("reset_spikes", 256'(bus.result_spikes), 256'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // Ticks in IDLE must not produce anything.
    idle_ticks(2);

    // Latency skip, tie, same-cycle tick + packet, completion.
    arm();
    for (int k = 0; k <= 4; k++) run_window(k);
    chk("done_after_run", 256'(bus.done), 256'(1));
    chk("range_clean_run", 256'(bus.range_error), 256'(0));
    idle_ticks(3);
    chk("no_result_in_done", 256'(n_results), 256'(3));

    // Range error, overrun with skipped picture number.
    arm();
    chk("rearm_done_low", 256'(bus.done), 256'(0));
    for (int k = 5; k <= 7; k++) run_window(k);
    repeat (4) step(1'b0, 0, 1'b0, 1'b0);
    model_tick(1'b0, 0, 0);
    step(1'b0, 0, 1'b1, 1'b0);
    chk("overrun_error_set", 256'(bus.overrun_error), 256'(1));
    chk("range_error_set", 256'(bus.range_error), 256'(1));
    drain();
    run_window(8);
    chk("done_after_skip", 256'(bus.done), 256'(1));

    // Re-arm clears errors, then reset in the middle of the vote.
    arm();
    chk("start_clears_done", 256'(bus.done), 256'(0));
    chk("start_clears_range", 256'(bus.range_error), 256'(0));
    chk("start_clears_overrun", 256'(bus.overrun_error), 256'(0));
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b1, 5, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    repeat (4) step(1'b0, 0, 1'b0, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    chk("midreset_result_valid", 256'(bus.result_valid), 256'(0));
    chk("midreset_spikes", 256'(bus.result_spikes), 256'(0));
    chk("midreset_class", 256'(bus.result_class), 256'(0));
    chk("midreset_count", 256'(bus.result_count), 256'(0));
    chk("midreset_picture_idx", 256'(bus.picture_idx), 256'(0));
    chk("midreset_done", 256'(bus.done), 256'(0));
    chk("midreset_range", 256'(bus.range_error), 256'(0));
    chk("midreset_overrun", 256'(bus.overrun_error), 256'(0));
    @(negedge clk);
    reset_n = 1'b1;
    saved = n_results;
    idle_ticks(4);
    chk("no_result_after_reset", 256'(n_results), 256'(saved));

    // Empty windows vote class 0 with count 0.
    arm();
    for (int k = 9; k <= 11; k++) run_window(k);
    chk("done_low_single_pic", 256'(bus.done), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_collector.md
Name: spike_collector

Overview:
- Downstream consumer of RANCNetworkGrid_3x2 output packets in the packet-replay bench/SoC path.
- Per tick window, collects the 8-bit output neuron indices into a NUM_OUTPUT-bit spike vector.
- Discards the windows covered by network pipeline latency, then emits one spike vector plus a class vote (argmax of per-class spike counts) per picture.
- Replaces ad-hoc bench logging with synthesizable, self-checking-friendly result capture.

Parameters:
- NUM_OUTPUT, 250, number of output neurons; valid indices 0..NUM_OUTPUT-1.
- NUM_CLASSES, 10, vote classes; neuron idx belongs to class idx mod NUM_CLASSES.
- NUM_PICTURE, 3, pictures to collect before done.
- LAYER_LATENCY, 2, leading tick windows discarded after start.
- IDX_W, 8, packet_out width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle arm pulse
- tick  in  1  one-cycle tick from tick counter; closes the current window
- packet_out  in  IDX_W  spiking output neuron index
- packet_out_valid  in  1  packet_out qualifier
- result_valid  out  1  one-cycle pulse, result fields valid
- result_spikes  out  NUM_OUTPUT  snapshot; bit (NUM_OUTPUT-1-idx) = neuron idx spiked
- result_class  out  4  winning class
- result_count  out  5  winning class spike count
- picture_idx  out  16  picture number of current result, 0-based
- done  out  1  high after NUM_PICTURE results, until start/reset
- range_error  out  1  sticky: index >= NUM_OUTPUT seen
- overrun_error  out  1  sticky: tick arrived during ARGMAX

Behaviour:
- Reset (async, reset_n=0): all outputs 0, working vector and class counters cleared, tick counter 0, state IDLE.
- States: IDLE, COLLECT, ARGMAX, DONE.
- IDLE: packets ignored. start -> COLLECT; clears vector, counters, picture_idx, and both errors.
- Collection (COLLECT and ARGMAX), on each valid packet with idx < NUM_OUTPUT:
  - Set working bit NUM_OUTPUT-1-idx.
  - Increment class counter (idx mod NUM_CLASSES) only if the bit was previously 0, so duplicates count once.
- idx >= NUM_OUTPUT: packet dropped, range_error set.
- tick in COLLECT: snapshot vector and counters, clear working copies, increment window count w.
  - w <= LAYER_LATENCY: snapshot discarded, stay COLLECT.
  - Otherwise: go to ARGMAX.
- Tick and valid packet in same cycle: packet goes to the new window, not the snapshot.
- ARGMAX: one class per cycle, classes 0..NUM_CLASSES-1, strict greater-than compare, so ties resolve to the lowest class.
- result_valid pulses NUM_CLASSES+1 cycles after the tick edge (11 by default). result_spikes, result_class, result_count and picture_idx hold until the next result.
- picture_idx = w-LAYER_LATENCY-1; increments after each result.
- After the last picture (picture_idx NUM_PICTURE-1) is reported: state DONE, done=1. Packets and ticks are ignored in DONE.
- tick during ARGMAX: overrun_error set. The arriving window is dropped, but w and the picture numbering still advance. ARGMAX completes normally.
- start outside IDLE/DONE: ignored. start in DONE re-arms exactly as from IDLE.
- Zero spikes in a window: result_class=0, result_count=0.
- Counter width 5 bits, sufficient for ceil(250/10)=25; no saturation needed.

Decomposition:
- Package rancpkg_out holds:
  - NUM_OUTPUT, NUM_CLASSES, CNT_W=5
  - state encoding for IDLE/COLLECT/ARGMAX/DONE
  - class-of-index function (mod).
- Sub-module spike_argmax: sequential argmax over the latched NUM_CLASSES x CNT_W counter array.
  - Ports: start, counts, done pulse, class, count.
- Top keeps collection, window counting and the FSM.

Test Plan:
- Reset mid-ARGMAX: pulse reset_n low -> all outputs 0 immediately, state IDLE; later ticks give no result_valid until start.
- Latency skip: start, ticks 1 and 2 each with packets {3} -> no result_valid. Window before tick 3 holds {3,13,23,5}; tick 3 -> 11 cycles later result_valid=1, picture_idx=0, result_class=3, result_count=3, result_spikes bits 246,236,226,244 set.
- Duplicates and tie: window {7,7,17,4,14} -> class 4 vs class 7, both count 2 -> result_class=4, result_count=2.
- Same-cycle tick + packet idx 9: idx 9 absent from the closing result and present in the next picture's result_spikes (bit 240).
- Errors: packet idx 250 -> range_error=1, no bit set. Tick 5 cycles after a result-producing tick -> overrun_error=1, and the next result shows picture_idx skipped by one.
- Completion: NUM_PICTURE=3 full run -> exactly 3 result_valid pulses (picture_idx 0,1,2), then done=1 and further ticks produce nothing; start pulse -> done=0, errors cleared.
